// File: rtl/pcie_reset_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pcie_reset_seq : PLL-gated PCIe bring-up sequencer with hold/train/retry |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pcie_reset_seq #(
  parameter int HOLD_CYCLES  = 64,
  parameter int LINK_TIMEOUT = 4096,
  parameter int DEBOUNCE     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       link_up,
  input  logic       retrain_req,
  output logic       pcie_rst_n,
  output logic       clk_gate,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] retry_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_TRAIN = 2'd2,
    S_UP    = 2'd3
  } state_t;

  localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LINK_TIMEOUT - 1);
  localparam logic [15:0] DEB_LAST     = 16'(DEBOUNCE - 1);

  state_t      cur_state;
  state_t      nxt_state;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [15:0] deb;
  logic [15:0] deb_nxt;
  logic [7:0]  retry_nxt;
  logic [7:0]  retry_sat;

  assign retry_sat = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
      cnt       <= 16'd0;
      deb       <= 16'd0;
      retry_cnt <= 8'd0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_nxt;
      deb       <= deb_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    cnt_nxt   = cnt;
    deb_nxt   = deb;
    retry_nxt = retry_cnt;
    case (cur_state)
      S_IDLE: begin
        if (pll_locked) begin
          nxt_state = S_HOLD;
          cnt_nxt   = 16'd0;
        end
      end
      S_HOLD: begin
        if (!pll_locked) begin
          nxt_state = S_IDLE;
        end else if (cnt == HOLD_LAST) begin
          nxt_state = S_TRAIN;
          cnt_nxt   = 16'd0;
          deb_nxt   = 16'd0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_TRAIN: begin
        // Qualification is tested before timeout so it wins a tie.
        if (!pll_locked) begin
          nxt_state = S_IDLE;
        end else if (link_up && (deb == DEB_LAST)) begin
          nxt_state = S_UP;
        end else if (cnt == TIMEOUT_LAST) begin
          nxt_state = S_HOLD;
          cnt_nxt   = 16'd0;
          retry_nxt = retry_sat;
        end else begin
          cnt_nxt = cnt + 16'd1;
          deb_nxt = link_up ? deb + 16'd1 : 16'd0;
        end
      end
      S_UP: begin
        if (!pll_locked) begin
          nxt_state = S_IDLE;
        end else if (!link_up || retrain_req) begin
          nxt_state = S_HOLD;
          cnt_nxt   = 16'd0;
          retry_nxt = retry_sat;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  assign state      = cur_state;
  assign pcie_rst_n = (cur_state == S_TRAIN) || (cur_state == S_UP);
  assign clk_gate   = (cur_state != S_IDLE);
  assign ready      = (cur_state == S_UP);

endmodule
`default_nettype wire

// File: tb/tb_pcie_reset_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pcie_reset_seq : vector table, directed corners and random vs model   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pcie_reset_seq;

  localparam int HOLD = 8;
  localparam int TO   = 32;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       link_up = 1'b0;
  logic       retrain_req = 1'b0;
  logic       pcie_rst_n;
  logic       clk_gate;
  logic       ready;
  logic [1:0] state;
  logic [7:0] retry_cnt;

  int total = 0;
  int bad   = 0;

  // Reference: phase code, completed cycles in phase, high-sample run, retries
  int m_phase   = 0;
  int m_elapsed = 0;
  int m_run     = 0;
  int m_retries = 0;

  typedef struct packed {
    logic        r;
    logic        p;
    logic        l;
    logic        t;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  pcie_reset_seq #(
    .HOLD_CYCLES (HOLD),
    .LINK_TIMEOUT(TO),
    .DEBOUNCE    (DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .link_up    (link_up),
    .retrain_req(retrain_req),
    .pcie_rst_n (pcie_rst_n),
    .clk_gate   (clk_gate),
    .ready      (ready),
    .state      (state),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] ex(input int st, input int rc);
    logic [1:0] s;
    s = 2'(st);
    return {s, (st >= 2), (st >= 1), (st == 3), 8'(rc)};
  endfunction

  function automatic logic [12:0] actual();
    return {state, pcie_rst_n, clk_gate, ready, retry_cnt};
  endfunction

  task automatic check(input string name, input logic [12:0] exp);
    total++;
    if (actual() !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h (state,rst_n,gate,ready,retry)", name, actual(), exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic model_next(input logic r, input logic p, input logic l, input logic t);
    if (!r) begin
      m_phase = 0; m_elapsed = 0; m_run = 0; m_retries = 0;
    end else if (m_phase != 0 && !p) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (p) begin m_phase = 1; m_elapsed = 0; end
    end else if (m_phase == 1) begin
      m_elapsed++;
      if (m_elapsed == HOLD) begin m_phase = 2; m_elapsed = 0; m_run = 0; end
    end else if (m_phase == 2) begin
      m_elapsed++;
      m_run = l ? m_run + 1 : 0;
      if (m_run == DEB) m_phase = 3;
      else if (m_elapsed == TO) begin
        m_phase = 1; m_elapsed = 0;
        m_retries = (m_retries < 255) ? m_retries + 1 : 255;
      end
    end else begin
      if (!l || t) begin
        m_phase = 1; m_elapsed = 0;
        m_retries = (m_retries < 255) ? m_retries + 1 : 255;
      end
    end
  endtask

  task automatic step(input logic r, input logic p, input logic l, input logic t);
    rst_n = r; pll_locked = p; link_up = l; retrain_req = t;
    model_next(r, p, l, t);
    @(posedge clk);
    #1;
    check("model", ex(m_phase, m_retries));
  endtask

  task automatic add(input logic r, input logic p, input logic l, input logic t,
                     input int st, input int rc);
    vec_t v;
    v.r = r; v.p = p; v.l = l; v.t = t; v.exp = ex(st, rc);
    vecs.push_back(v);
  endtask

  task automatic goto_state(input int target, input logic l);
    int n;
    n = 0;
    while (int'(state) != target && n < 100) begin
      step(1'b1, 1'b1, l, 1'b0);
      n++;
    end
    check_int($sformatf("reach_state%0d", target), int'(state), target);
  endtask

  initial begin
    int n;
    logic pat [8];
    logic link_hi;

    // Bring-up, retrain in UP, PLL loss in HOLD, reset clearing RETRY_CNT
    add(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < HOLD; i++) add(1, 1, 0, 0, 1, 0);
    add(1, 1, 1, 0, 2, 0);
    for (int i = 0; i < DEB - 1; i++) add(1, 1, 1, 0, 2, 0);
    add(1, 1, 1, 0, 3, 0);
    add(1, 1, 1, 0, 3, 0);
    add(1, 1, 1, 1, 1, 1);
    add(1, 1, 1, 1, 1, 1);
    add(1, 0, 1, 0, 0, 1);
    add(1, 0, 1, 0, 0, 1);
    add(1, 1, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].p, vecs[i].l, vecs[i].t);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Timeout: 32 TRAIN cycles then HOLD with one retry, then saturation
    step(1'b0, 1'b1, 1'b0, 1'b0);
    goto_state(2, 1'b0);
    n = 0;
    while (state == 2'd2 && n < 100) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    check_int("train_len", n, TO);
    check_int("timeout_state", int'(state), 1);
    check_int("timeout_retry", int'(retry_cnt), 1);
    for (int i = 0; i < 299 * (HOLD + TO); i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check_int("retry_saturated", int'(retry_cnt), 255);

    // Debounce glitch
    step(1'b0, 1'b1, 1'b0, 1'b0);
    goto_state(2, 1'b0);
    pat[0] = 1; pat[1] = 1; pat[2] = 1; pat[3] = 0;
    pat[4] = 1; pat[5] = 1; pat[6] = 1; pat[7] = 1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, pat[i], 1'b0);
      check_int($sformatf("glitch_ready%0d", i), int'(ready), (i == 7) ? 1 : 0);
    end

    // Link drop in UP, then retrain request ignored in TRAIN
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("link_drop", ex(1, 1));
    goto_state(2, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("retrain_in_train", ex(2, 1));
    for (int i = 0; i < DEB; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    check("up_again", ex(3, 1));

    // PLL loss coincident with retrain in UP
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("pll_loss", ex(0, 1));

    // Reset during HOLD cycle 5, then a full HOLD on re-entry
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("hold_c5", ex(1, 1));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("mid_hold_reset", ex(0, 0));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n = 1;
    while (state == 2'd1 && n < 100) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (state == 2'd1) n++;
    end
    check_int("rehold_len", n, HOLD);

    // Random traffic against the reference
    step(1'b0, 1'b1, 1'b0, 1'b0);
    link_hi = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic r, p, l, t;
      if ($urandom_range(0, 49) == 0) link_hi = ~link_hi;
      r = ($urandom_range(0, 299) != 0);
      p = ($urandom_range(0, 149) != 0);
      l = link_hi ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 39) == 0);
      step(r, p, l, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
